// File: rtl/rs232_rx_fifo.sv
// Receive-side byte buffer between the RS-232 receiver and the CPU IO bus.
// A two-state FSM drains the receiver's rdy/done handshake into a first-word-fall-through FIFO.
module rs232_rx_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_rdy,
    input  logic [DW-1:0] rx_data,
    output logic          rx_done,
    input  logic          pop,
    input  logic          clr_ovf,
    output logic [DW-1:0] q,
    output logic          rdy,
    output logic          full,
    output logic          ovf,
    output logic [AW:0]   count
);

    localparam int unsigned Depth    = 1 << AW;
    localparam logic [AW:0] CntFull  = Depth[AW:0];

    typedef enum logic {
        StIdle,
        StHold
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic            r_rx_done;
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [AW:0]     r_count;
    logic            r_ovf;
    logic [DW-1:0]   r_mem [Depth];

    logic            w_take;
    logic            w_rdy;
    logic            w_full;
    logic            w_pop_eff;
    logic            w_push;
    logic            w_discard;

    assign w_rdy     = (r_count != '0);
    assign w_full    = (r_count == CntFull);
    assign w_pop_eff = pop & w_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_push    = w_take & (~w_full | w_pop_eff);
    assign w_discard = w_take & ~w_push;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (rx_rdy) w_state_next = StHold;
            // rx_rdy lags done by a cycle; waiting for it to drop keeps one push per byte.
            StHold: if (!rx_rdy) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_take = 1'b0;
        unique case (r_state)
            StIdle:  w_take = rx_rdy;
            StHold:  w_take = 1'b0;
            default: w_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_done <= 1'b0;
        end else begin
            r_rx_done <= w_take;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop_eff) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop_eff})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set wins over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_discard) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= rx_data;
        end
    end

    assign q       = w_rdy ? r_mem[r_rp] : '0;
    assign rdy     = w_rdy;
    assign full    = w_full;
    assign ovf     = r_ovf;
    assign count   = r_count;
    assign rx_done = r_rx_done;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed bench for rs232_rx_fifo: receiver handshake model, pops, overflow, wrap and reset.
module tb_rs232_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       pop;
    logic       clr_ovf;
    logic [7:0] q;
    logic       rdy;
    logic       full;
    logic       ovf;
    logic [4:0] count;

    int n_tests;
    int n_fail;

    rs232_rx_fifo #(
        .AW(4),
        .DW(8)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .rx_rdy (rx_rdy),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .pop    (pop),
        .clr_ovf(clr_ovf),
        .q      (q),
        .rdy    (rdy),
        .full   (full),
        .ovf    (ovf),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: holds rx_rdy one cycle past done, then drops it; counts done pulses.
    task automatic push_byte(input logic [7:0] d, input logic with_pop, input logic with_clr,
                             output int pulses);
        pulses  = 0;
        rx_data = d;
        rx_rdy  = 1'b1;
        pop     = with_pop;
        clr_ovf = with_clr;
        tick();
        pop     = 1'b0;
        clr_ovf = 1'b0;
        if (rx_done) pulses++;
        tick();
        if (rx_done) pulses++;
        rx_rdy = 1'b0;
        tick();
        if (rx_done) pulses++;
        tick();
        if (rx_done) pulses++;
    endtask

    task automatic pop_one();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         p;
        logic [7:0] exp_q[$];
        logic [7:0] nxt;
        logic [7:0] head;

        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        pop     = 1'b0;
        clr_ovf = 1'b0;
        tick();
        tick();
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_rdy", 32'(rdy), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_q", 32'(q), 32'd0);
        check_eq("rst_done", 32'(rx_done), 32'd0);
        rst = 1'b0;
        tick();

        // Single byte
        push_byte(8'hA5, 1'b0, 1'b0, p);
        check_eq("single_pulses", 32'(p), 32'd1);
        check_eq("single_count", 32'(count), 32'd1);
        check_eq("single_rdy", 32'(rdy), 32'd1);
        check_eq("single_q", 32'(q), 32'hA5);
        pop_one();
        check_eq("single_pop_count", 32'(count), 32'd0);
        check_eq("single_pop_rdy", 32'(rdy), 32'd0);
        check_eq("single_pop_q", 32'(q), 32'd0);

        // Pop while empty is ignored
        pop_one();
        check_eq("empty_pop_count", 32'(count), 32'd0);

        // Fill
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i), 1'b0, 1'b0, p);
        end
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_count", 32'(count), 32'd16);

        // Overflow
        push_byte(8'h55, 1'b0, 1'b0, p);
        check_eq("ovf_pulses", 32'(p), 32'd1);
        check_eq("ovf_count", 32'(count), 32'd16);
        check_eq("ovf_flag", 32'(ovf), 32'd1);
        check_eq("ovf_head", 32'(q), 32'h00);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ovf_clr", 32'(ovf), 32'd0);
        push_byte(8'h66, 1'b0, 1'b1, p);
        check_eq("ovf_set_wins", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ovf_clr2", 32'(ovf), 32'd0);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("drain_q%0d", i), 32'(q), 32'(i));
            if (i == 15) check_eq("drain_rdy_before_last", 32'(rdy), 32'd1);
            pop_one();
        end
        check_eq("drain_rdy", 32'(rdy), 32'd0);
        check_eq("drain_full", 32'(full), 32'd0);

        // Full + push + pop in one cycle
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(8'h10 + i), 1'b0, 1'b0, p);
        end
        push_byte(8'h77, 1'b1, 1'b0, p);
        check_eq("fullpp_count", 32'(count), 32'd16);
        check_eq("fullpp_ovf", 32'(ovf), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check_eq($sformatf("fullpp_q%0d", i), 32'(q), 32'(8'h10 + i));
            pop_one();
        end
        check_eq("fullpp_last", 32'(q), 32'h77);
        pop_one();
        check_eq("fullpp_empty", 32'(rdy), 32'd0);

        // Empty + push + pop in one cycle
        push_byte(8'h3C, 1'b1, 1'b0, p);
        check_eq("emptypp_count", 32'(count), 32'd1);
        check_eq("emptypp_q", 32'(q), 32'h3C);
        pop_one();

        // Wrap-around, count held near 3
        nxt = 8'h80;
        for (int i = 0; i < 3; i++) begin
            push_byte(nxt, 1'b0, 1'b0, p);
            exp_q.push_back(nxt);
            nxt++;
        end
        for (int i = 0; i < 40; i++) begin
            push_byte(nxt, 1'b0, 1'b0, p);
            exp_q.push_back(nxt);
            nxt++;
            head = exp_q.pop_front();
            check_eq($sformatf("wrap_q%0d", i), 32'(q), 32'(head));
            pop_one();
            check_eq($sformatf("wrap_cnt%0d", i), 32'({full, rdy, count}), {25'd0, 2'b01, 5'd3});
        end
        for (int i = 0; i < 3; i++) begin
            head = exp_q.pop_front();
            check_eq($sformatf("wrap_tail%0d", i), 32'(q), 32'(head));
            pop_one();
        end

        // Reset mid-handshake with count 5
        for (int i = 0; i < 4; i++) begin
            push_byte(8'(8'hC0 + i), 1'b0, 1'b0, p);
        end
        rx_data = 8'hC4;
        rx_rdy  = 1'b1;
        tick();
        check_eq("midrst_pre_count", 32'(count), 32'd5);
        check_eq("midrst_pre_done", 32'(rx_done), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst_done", 32'(rx_done), 32'd0);
        check_eq("midrst_count", 32'(count), 32'd0);
        check_eq("midrst_rdy", 32'(rdy), 32'd0);
        tick();
        rst     = 1'b0;
        rx_data = 8'hE2;
        p       = 0;
        tick();
        if (rx_done) p++;
        tick();
        if (rx_done) p++;
        rx_rdy = 1'b0;
        tick();
        if (rx_done) p++;
        tick();
        if (rx_done) p++;
        check_eq("midrst_pulses", 32'(p), 32'd1);
        check_eq("midrst_new_count", 32'(count), 32'd1);
        check_eq("midrst_new_q", 32'(q), 32'hE2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs232_rx_fifo.md
Name: rs232_rx_fifo

Overview:
- Receive-side byte buffer between the RS-232 receiver (RS232R) and the CPU IO bus.
- Drains bytes from the receiver's rdy/done handshake into a first-word-fall-through FIFO.
- Presents the head byte and status at IO word addresses 2 (data) and 3 (status).
- Lets software tolerate bursts at the fast bitrate without polling every byte.

Parameters:
- AW, 4, address width; depth = 2**AW entries.
- DW, 8, data width in bits.

Ports:
- clk  in  1  system clock (25 MHz CPU clock).
- rst  in  1  asynchronous, active-high reset.
- rx_rdy  in  1  receiver holds a byte; stays high until acknowledged.
- rx_data  in  DW  receiver byte, valid while rx_rdy=1.
- rx_done  out  1  one-cycle acknowledge to the receiver's done input.
- pop  in  1  CPU read strobe (rd & ioenb & iowadr==2); removes the head entry.
- clr_ovf  in  1  CPU write strobe to status (wr & ioenb & iowadr==3); clears ovf.
- q  out  DW  head byte, first-word-fall-through.
- rdy  out  1  FIFO not empty.
- full  out  1  count == 2**AW.
- ovf  out  1  sticky: a byte was discarded because the FIFO was full.
- count  out  AW+1  number of stored entries.

Behaviour:
- Reset (async, rst=1):
  - Write and read pointers 0, count 0, ovf 0, rx_done 0, FSM in IDLE.
  - Outputs: q=0, rdy=0, full=0.
  - Storage array is not reset.
  - An in-flight handshake is abandoned. After release, rx_rdy still high is treated as a fresh byte.
- Ingress FSM, two states:
  - IDLE: if rx_rdy=1, register rx_done=1 and go to HOLD on that edge.
    - If accepted, write rx_data into mem[wp] and increment wp (mod 2**AW).
    - Accepted means ~full | pop_eff.
    - If not accepted, the byte is discarded and ovf is set to 1.
  - HOLD: rx_done=0. Stay until rx_rdy=0, then go to IDLE.
    - This guarantees exactly one push per receiver byte, even though rx_rdy drops one cycle after done.
  - rx_done is high for exactly one cycle per byte.
- Egress:
  - pop_eff = pop & rdy.
  - On pop_eff, increment rp (mod 2**AW).
  - pop while empty is ignored: no pointer or count change.
- Count update:
  - count += push - pop_eff, evaluated in the same cycle.
  - Simultaneous push and pop when full: push accepted, count stays at 2**AW, ovf unchanged.
  - Simultaneous push and pop when empty: pop ignored, push accepted, count becomes 1.
- Outputs:
  - q = rdy ? mem[rp] : 0, combinational from registered pointers.
  - A pushed byte is visible on q the cycle after the push edge.
  - rdy = (count != 0); full = (count == 2**AW). Both are derived from the registered count.
- ovf:
  - Set on a discard.
  - Cleared by clr_ovf.
  - Set wins over clear in the same cycle.
- Pointer wrap: pointers are AW bits and wrap naturally. Full and empty are distinguished only by count.
- IO integration (top level):
  - Status word at iowadr 3 becomes {28'b0, ovf, full, rdyTx, rdy}. Bit 0 keeps its meaning.
  - The data word at iowadr 2 is {24'b0, q}.
  - pop uses the same strobe that previously drove the receiver's doneRx.

Test Plan:
- Single byte: after reset, rx_rdy=1 with rx_data=8'hA5; receiver drops rx_rdy 1 cycle after rx_done -> exactly one rx_done pulse, count=1, rdy=1, q=8'hA5 one cycle after the push; pop -> count=0, rdy=0, q=0.
- Order and fill: push 16 bytes 8'h00..8'h0F -> full=1, count=16; pop 16 times -> q sequence 00..0F, and rdy falls after the 16th pop.
- Overflow: with the FIFO full, push 8'h55 -> rx_done pulses, count stays 16, ovf=1, head still 8'h00; clr_ovf -> ovf=0. With clr_ovf and a discard in the same cycle, ovf stays 1.
- Simultaneous events:
  - Full plus push 8'h77 plus pop in one cycle -> count 16, ovf 0, 8'h77 read last.
  - Empty plus push plus pop -> count 1.
- Wrap-around: interleave 40 pushes and pops keeping count at 3 -> data order preserved across pointer wrap, no spurious full or empty.
- Reset mid-handshake: assert rst in HOLD with count=5 -> rx_done=0, count=0, rdy=0 immediately. Release with rx_rdy still high -> one new push and one rx_done.
